// File: rtl/expr_parser_fsm_pkg.sv
// Shared definitions for the expression syntax checker: parser states,
// error codes and the ASCII characters the grammar recognises.
package expr_parser_fsm_pkg;

    // Parser states
    typedef enum logic [1:0] {
        StExp = 2'd0,  // operand or '(' expected
        StNum = 2'd1,  // inside a number literal
        StCls = 2'd2,  // just after ')'
        StErr = 2'd3   // sticky error, absorbs all input
    } state_e;

    // Error codes reported on o_err_code
    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrBadChar  = 3'd1;
    localparam logic [2:0] ErrSyntax   = 3'd2;
    localparam logic [2:0] ErrUnmatch  = 3'd3;
    localparam logic [2:0] ErrDepth    = 3'd4;
    localparam logic [2:0] ErrNumLong  = 3'd5;

    // ASCII constants
    localparam logic [7:0] ChZero  = 8'h30;
    localparam logic [7:0] ChNine  = 8'h39;
    localparam logic [7:0] ChPlus  = 8'h2B;
    localparam logic [7:0] ChStar  = 8'h2A;
    localparam logic [7:0] ChMinus = 8'h2D;
    localparam logic [7:0] ChLpar  = 8'h28;
    localparam logic [7:0] ChRpar  = 8'h29;
    localparam logic [7:0] ChSpace = 8'h20;

endpackage

// File: rtl/expr_parser_fsm_char_class.sv
// Combinational character classifier: exactly one class output is high for
// any input byte. Disabled '-' or ' ' fall into the bad class.
module expr_parser_fsm_char_class
    import expr_parser_fsm_pkg::*;
#(
    parameter bit ALLOW_MINUS = 1'b1,
    parameter bit SKIP_SPACE  = 1'b1
) (
    input  logic [7:0] i_char,
    output logic       o_is_digit,
    output logic       o_is_op,
    output logic       o_is_lpar,
    output logic       o_is_rpar,
    output logic       o_is_space,
    output logic       o_is_bad
);

    logic w_digit;
    logic w_op;
    logic w_lpar;
    logic w_rpar;
    logic w_space;

    assign w_digit = (i_char >= ChZero) && (i_char <= ChNine);
    assign w_op    = (i_char == ChPlus) || (i_char == ChStar) ||
                     (ALLOW_MINUS && (i_char == ChMinus));
    assign w_lpar  = (i_char == ChLpar);
    assign w_rpar  = (i_char == ChRpar);
    assign w_space = SKIP_SPACE && (i_char == ChSpace);

    // Priority chain keeps the outputs one-hot even if classes were to overlap
    always_comb begin
        o_is_digit = 1'b0;
        o_is_op    = 1'b0;
        o_is_lpar  = 1'b0;
        o_is_rpar  = 1'b0;
        o_is_space = 1'b0;
        o_is_bad   = 1'b0;
        if (w_digit)      o_is_digit = 1'b1;
        else if (w_op)    o_is_op    = 1'b1;
        else if (w_lpar)  o_is_lpar  = 1'b1;
        else if (w_rpar)  o_is_rpar  = 1'b1;
        else if (w_space) o_is_space = 1'b1;
        else              o_is_bad   = 1'b1;
    end

endmodule

// File: rtl/expr_parser_fsm.sv
// Streaming syntax checker for infix expressions, one ASCII char per
// accepted beat. Flags complete expressions, tracks paren depth and number
// literal count, and latches the first error until reset or restart.
module expr_parser_fsm
    import expr_parser_fsm_pkg::*;
#(
    parameter int unsigned MAX_DEPTH   = 7,
    parameter int unsigned MAX_DIGITS  = 4,
    parameter bit          ALLOW_MINUS = 1'b1,
    parameter bit          SKIP_SPACE  = 1'b1,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEPTH_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_clr_n,
    input  logic               i_restart,
    input  logic               i_in_valid,
    input  logic [7:0]         i_in,
    output logic               o_out,
    output logic               o_err,
    output logic [2:0]         o_err_code,
    output logic [DEPTH_W-1:0] o_depth,
    output logic [CNT_W-1:0]   o_tok_cnt
);

    localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 1);

    state_e             r_state, w_state_d;
    logic [DEPTH_W-1:0] r_depth, w_depth_d;
    logic [DCNT_W-1:0]  r_dcnt, w_dcnt_d;
    logic [CNT_W-1:0]   r_tok_cnt, w_tok_d;
    logic [2:0]         r_err_code, w_err_d;
    logic               r_out, w_out_d;
    logic               r_err, w_err_flag_d;

    logic w_digit, w_op, w_lpar, w_rpar, w_space, w_bad;
    logic w_depth_max, w_depth_zero, w_dcnt_max, w_tok_sat;

    expr_parser_fsm_char_class #(
        .ALLOW_MINUS (ALLOW_MINUS),
        .SKIP_SPACE  (SKIP_SPACE)
    ) u_char_class (
        .i_char     (i_in),
        .o_is_digit (w_digit),
        .o_is_op    (w_op),
        .o_is_lpar  (w_lpar),
        .o_is_rpar  (w_rpar),
        .o_is_space (w_space),
        .o_is_bad   (w_bad)
    );

    assign w_depth_max  = (r_depth == DEPTH_W'(MAX_DEPTH));
    assign w_depth_zero = (r_depth == '0);
    assign w_dcnt_max   = (r_dcnt == DCNT_W'(MAX_DIGITS));
    assign w_tok_sat    = (r_tok_cnt == {CNT_W{1'b1}});

    // Next-state decode; spaces (when skipped) match no branch and change nothing
    always_comb begin
        w_state_d = r_state;
        w_depth_d = r_depth;
        w_dcnt_d  = r_dcnt;
        w_tok_d   = r_tok_cnt;
        w_err_d   = r_err_code;
        if (i_in_valid) begin
            unique case (r_state)
                StExp: begin
                    if (w_digit) begin
                        w_state_d = StNum;
                        w_dcnt_d  = DCNT_W'(1);
                        if (!w_tok_sat) w_tok_d = r_tok_cnt + CNT_W'(1);
                    end else if (w_lpar) begin
                        if (w_depth_max) begin
                            w_state_d = StErr;
                            w_err_d   = ErrDepth;
                        end else begin
                            w_depth_d = r_depth + DEPTH_W'(1);
                        end
                    end else if (w_op || w_rpar) begin
                        w_state_d = StErr;
                        w_err_d   = ErrSyntax;
                    end else if (w_bad) begin
                        w_state_d = StErr;
                        w_err_d   = ErrBadChar;
                    end
                end
                StNum, StCls: begin
                    if (w_digit && (r_state == StNum)) begin
                        if (w_dcnt_max) begin
                            w_state_d = StErr;
                            w_err_d   = ErrNumLong;
                        end else begin
                            w_dcnt_d = r_dcnt + DCNT_W'(1);
                        end
                    end else if (w_op) begin
                        w_state_d = StExp;
                    end else if (w_rpar) begin
                        if (w_depth_zero) begin
                            w_state_d = StErr;
                            w_err_d   = ErrUnmatch;
                        end else begin
                            w_depth_d = r_depth - DEPTH_W'(1);
                            w_state_d = StCls;
                        end
                    end else if (w_digit || w_lpar) begin
                        w_state_d = StErr;
                        w_err_d   = ErrSyntax;
                    end else if (w_bad) begin
                        w_state_d = StErr;
                        w_err_d   = ErrBadChar;
                    end
                end
                StErr: ;
                default: ;
            endcase
        end
        w_out_d      = ((w_state_d == StNum) || (w_state_d == StCls)) && (w_depth_d == '0);
        w_err_flag_d = (w_err_d != ErrNone);
    end

    // State and output registers; restart has priority over any incoming char
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state    <= StExp;
            r_depth    <= '0;
            r_dcnt     <= '0;
            r_tok_cnt  <= '0;
            r_err_code <= ErrNone;
            r_out      <= 1'b0;
            r_err      <= 1'b0;
        end else if (i_restart) begin
            r_state    <= StExp;
            r_depth    <= '0;
            r_dcnt     <= '0;
            r_tok_cnt  <= '0;
            r_err_code <= ErrNone;
            r_out      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_depth    <= w_depth_d;
            r_dcnt     <= w_dcnt_d;
            r_tok_cnt  <= w_tok_d;
            r_err_code <= w_err_d;
            r_out      <= w_out_d;
            r_err      <= w_err_flag_d;
        end
    end

    assign o_out      = r_out;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_depth    = r_depth;
    assign o_tok_cnt  = r_tok_cnt;

endmodule
